// File: rtl/adder_pkg.sv
// Shared constants for the demux-based full adder: select width and the
// minterm masks that pick the demux lines feeding each output.
package adder_pkg;

    localparam int SEL_W = 3;
    localparam int LINES = 1 << SEL_W;

    // Bit i set means minterm i (sel == i) contributes to the output.
    localparam logic [LINES-1:0] SUM_MINTERMS   = 8'b1001_0110;
    localparam logic [LINES-1:0] CARRY_MINTERMS = 8'b1110_1000;

endpackage

// File: rtl/demux_1to8.sv
// Combinational 1-to-8 demultiplexer: routes d onto line y[sel], all other
// lines low.
module demux_1to8
    import adder_pkg::*;
(
    input  logic             d,
    input  logic [SEL_W-1:0] sel,
    output logic [LINES-1:0] y
);

    // Per-line compare rather than an indexed write so an unknown sel
    // yields unknown lines instead of silently dropping the write.
    always_comb begin
        y = '0;
        for (int i = 0; i < LINES; i++) begin
            y[i] = d & (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/code.sv
// Single-bit full adder: operands select a demux line, minterm masks reduce
// the lines to sum and carry, and both results are registered.
// No handshake: one operand triple is accepted on every rising clk edge and
// its result is visible on S/Cout after that edge until the next one.
module code
    import adder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic [LINES-1:0] m;
    logic             s_next;
    logic             c_next;

    demux_1to8 u_demux (
        .d   (1'b1),
        .sel ({A, B, Cin}),
        .y   (m)
    );

    assign s_next = |(m & SUM_MINTERMS);
    assign c_next = |(m & CARRY_MINTERMS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S    <= 1'b0;
            Cout <= 1'b0;
        end else begin
            S    <= s_next;
            Cout <= c_next;
        end
    end

endmodule

// File: tb/tb_code.sv
// Bench for the demux-based full adder: arithmetic reference model feeding a
// scoreboard queue, plus direct checks for reset, latency and the demux.
module tb_code;

    logic clk;
    logic rst;
    logic A, B, Cin;
    logic S, Cout;

    logic       dd;
    logic [2:0] dsel;
    logic [7:0] dy;

    logic [1:0] exp_q[$];
    int         total;
    int         passed;

    code dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout)
    );

    demux_1to8 u_dmx (
        .d   (dd),
        .sel (dsel),
        .y   (dy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Driver: change operands mid-cycle and record the arithmetic result.
    task automatic apply(input logic a, input logic b, input logic c);
        int sum;
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = c;
        sum = int'(a) + int'(b) + int'(c);
        exp_q.push_back(2'(sum));
    endtask

    // Monitor: each captured result is compared just after the rising edge.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("adder_out", {6'b0, Cout, S}, {6'b0, e});
            end
        end
    end

    initial begin
        logic [7:0] onehot;
        total  = 0;
        passed = 0;
        rst = 1'b1;
        A   = 1'b0;
        B   = 1'b0;
        Cin = 1'b0;
        dd  = 1'b0;
        dsel = 3'd0;
        #1;
        check("reset_state", {6'b0, Cout, S}, 8'd0);

        // Demux unit test
        for (int i = 0; i < 8; i++) begin
            dsel = 3'(i);
            dd   = 1'b1;
            onehot = 8'd1 << i;
            #1;
            check("demux_d1", dy, onehot);
            dd = 1'b0;
            #1;
            check("demux_d0", dy, 8'd0);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep in order 000..111
        for (int i = 0; i < 8; i++) begin
            apply(i[2], i[1], i[0]);
        end

        // Async reset between edges with outputs at 1,1
        apply(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst", {6'b0, Cout, S}, 8'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold", {6'b0, Cout, S}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(2'd3);

        // Latency: a mid-cycle change must not reach the outputs early
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        #1;
        check("latency_hold", {6'b0, Cout, S}, 8'd0);

        // Back-to-back toggling 011 / 100
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) apply(1'b0, 1'b1, 1'b1);
            else            apply(1'b1, 1'b0, 1'b0);
        end

        // Random arithmetic property
        for (int i = 0; i < 1000; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        check("queue_drain", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
